// File: rtl/countcap_if.sv
// countcap_if: Wishbone slave bus bundle used by the countcap capture block.
interface countcap_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [3:0]  adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;

   modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
   modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/countcap.sv
// countcap: Wishbone input-capture block measuring rising-edge periods on CH inputs.
// Define COUNTCAP_HIGHTIME_EN to build per-channel high-time measurement (CHSEL/HIGH).
module countcap #(
   parameter int CH = 8,
   parameter int W  = 32
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   countcap_if.slave     wb,
   input  logic [CH-1:0] cap_i
);
   localparam logic [W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARMING, MEASURE} ch_state_e;

   logic          ack_reg;
   logic [31:0]   dat_reg;
   logic [CH-1:0] ctrl_reg;
   logic [CH-1:0] valid_reg;
   logic [CH-1:0] ovr_reg;
   logic [CH-1:0] s1_reg;
   logic [CH-1:0] s2_reg;
   logic [CH-1:0] s3_reg;

   logic          accept;
   logic          rd_acc;
   logic          wr_acc;
   logic [CH-1:0] en_eff;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] capture;
   logic [CH-1:0] period_rd;
   logic [CH-1:0] ovr_w1c;
   logic [CH-1:0] ovr_set;
   logic [CH-1:0] valid_next;
   logic [CH-1:0] ovr_next;
   logic [31:0]   rd_data;
   logic [W-1:0]  period_arr [CH];
   logic          wb_unused;

   assign accept = wb.cyc_i & wb.stb_i & ~ack_reg;
   assign rd_acc = accept & ~wb.we_i;
   assign wr_acc = accept & wb.we_i;
   assign rise   = s2_reg & ~s3_reg;
   assign fall   = ~s2_reg & s3_reg;

   // A CTRL write accepted this edge takes effect now, so a disable beats a same-cycle capture.
   assign en_eff  = (wr_acc && wb.adr_i == 4'd0) ? wb.dat_i[CH-1:0] : ctrl_reg;
   assign ovr_w1c = (wr_acc && wb.adr_i == 4'd2) ? wb.dat_i[CH-1:0] : '0;

   assign wb_unused = ^wb.dat_i[31:CH];

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      ch_state_e    state_reg;
      ch_state_e    state_next;
      logic [W-1:0] cnt_reg;
      logic [W-1:0] cnt_next;
      logic [W-1:0] period_reg;
      logic         cap_now;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            period_reg <= '0;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (cap_now) begin
               period_reg <= cnt_reg;
            end
         end
      end

      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         cap_now    = 1'b0;
         case (state_reg)
            IDLE: begin
               state_next = ARMING;
            end
            ARMING: begin
               if (rise[gi]) begin
                  state_next = MEASURE;
                  cnt_next   = W'(1);
               end
            end
            MEASURE: begin
               if (rise[gi]) begin
                  cap_now  = 1'b1;
                  cnt_next = W'(1);
               end else if (cnt_reg != CNT_MAX) begin
                  cnt_next = cnt_reg + W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
         if (!en_eff[gi]) begin
            state_next = IDLE;
            cnt_next   = '0;
            cap_now    = 1'b0;
         end
      end

      assign capture[gi]    = cap_now;
      assign period_rd[gi]  = rd_acc && (wb.adr_i == 4'(8 + gi));
      assign period_arr[gi] = period_reg;
   end

   // A read racing a capture returns the old value and must neither clear valid nor flag overrun.
   assign ovr_set    = capture & valid_reg & ~period_rd;
   assign valid_next = (valid_reg & ~period_rd) | capture;
   assign ovr_next   = (ovr_reg & ~ovr_w1c) | ovr_set;

`ifdef COUNTCAP_HIGHTIME_EN
   logic [2:0]   chsel_reg;
   logic [W-1:0] high_arr [CH];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         chsel_reg <= '0;
      end else if (wr_acc && wb.adr_i == 4'd3) begin
         chsel_reg <= wb.dat_i[2:0];
      end
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_high
      logic [W-1:0] hcnt_reg;
      logic [W-1:0] high_reg;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            hcnt_reg <= '0;
            high_reg <= '0;
         end else begin
            if (rise[gi]) begin
               hcnt_reg <= W'(1);
            end else if (s2_reg[gi] && hcnt_reg != CNT_MAX) begin
               hcnt_reg <= hcnt_reg + W'(1);
            end
            if (fall[gi]) begin
               high_reg <= hcnt_reg;
            end
         end
      end

      assign high_arr[gi] = high_reg;
   end
`else
   logic fall_unused;
   assign fall_unused = ^fall;
`endif

   always_comb begin
      rd_data = '0;
      case (wb.adr_i)
         4'd0: rd_data[CH-1:0] = ctrl_reg;
         4'd1: rd_data[CH-1:0] = valid_reg;
         4'd2: rd_data[CH-1:0] = ovr_reg;
`ifdef COUNTCAP_HIGHTIME_EN
         4'd3: rd_data[2:0] = chsel_reg;
         4'd4: rd_data = 32'(high_arr[chsel_reg]);
`endif
         default: begin
            if (wb.adr_i[3]) begin
               rd_data = 32'(period_arr[wb.adr_i[2:0]]);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_reg   <= 1'b0;
         dat_reg   <= '0;
         ctrl_reg  <= '0;
         valid_reg <= '0;
         ovr_reg   <= '0;
         s1_reg    <= '0;
         s2_reg    <= '0;
         s3_reg    <= '0;
      end else begin
         ack_reg   <= accept;
         dat_reg   <= rd_acc ? rd_data : '0;
         ctrl_reg  <= en_eff;
         valid_reg <= valid_next;
         ovr_reg   <= ovr_next;
         s1_reg    <= cap_i;
         s2_reg    <= s1_reg;
         s3_reg    <= s2_reg;
      end
   end

   assign wb.ack_o = ack_reg;
   assign wb.dat_o = dat_reg;
endmodule

// File: tb/tb_countcap.sv
// tb_countcap: randomized scoreboard bench for countcap; a timestamp-based model predicts every bus response.
module tb_countcap;
   typedef struct {
      logic        we;
      logic [3:0]  adr;
      logic [31:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cap = '0;

   countcap_if bus ();

   countcap #(.CH(8), .W(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .wb      (bus),
      .cap_i   (cap)
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail = 0;
   longint cyc_count = 0;

   // waveform generator state; rise_at/fall_at hold the clock edge at which the DUT sees the transition
   int     per_cfg [8] = '{default: 0};
   int     hi_cfg  [8] = '{default: 0};
   int     per_cur [8] = '{default: 0};
   int     hi_cur  [8] = '{default: 0};
   int     ph      [8] = '{default: 0};
   longint rise_at [8] = '{default: 0};
   longint fall_at [8] = '{default: 0};

   // reference model state
   logic        m_ack;
   logic [7:0]  m_ctrl, m_valid, m_ovr;
   logic [2:0]  m_chsel;
   logic        m_armed [8];
   longint      m_last  [8];
   longint      m_hrise [8];
   logic [31:0] m_per   [8];
   logic [31:0] m_high  [8];
   exp_t        exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat32(input longint d);
      if (d > 64'd4294967295) return 32'hFFFFFFFF;
      return 32'(d);
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         4'd0: r[7:0] = m_ctrl;
         4'd1: r[7:0] = m_valid;
         4'd2: r[7:0] = m_ovr;
`ifdef COUNTCAP_HIGHTIME_EN
         4'd3: r[2:0] = m_chsel;
         4'd4: r = m_high[m_chsel];
`endif
         default: if (a >= 4'd8) r = m_per[a - 4'd8];
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      for (int n = 0; n < 8; n++) begin
         logic nv;
         if (per_cur[n] == 0) begin
            if (per_cfg[n] != 0) begin
               per_cur[n] = per_cfg[n];
               hi_cur[n]  = hi_cfg[n];
               ph[n]      = 0;
            end
         end else if (ph[n] + 1 >= per_cur[n]) begin
            ph[n]      = 0;
            per_cur[n] = per_cfg[n];
            hi_cur[n]  = hi_cfg[n];
         end else begin
            ph[n]++;
         end
         nv = (per_cur[n] != 0) && (ph[n] < hi_cur[n]);
         if (nv && !cap[n]) rise_at[n] = cyc_count + 3;
         if (!nv && cap[n]) fall_at[n] = cyc_count + 3;
         cap[n] = nv;
      end
   end

   always @(posedge clk) begin
      logic       acc, rd, wr;
      logic [7:0] ctrl_new, w1c, ovr_set;
      cyc_count++;
      if (!rst_n) begin
         m_ack = 1'b0; m_ctrl = '0; m_valid = '0; m_ovr = '0; m_chsel = '0;
         for (int n = 0; n < 8; n++) begin
            m_armed[n] = 1'b0; m_last[n] = 0; m_hrise[n] = -1;
            m_per[n] = '0; m_high[n] = '0;
         end
         exp_q.delete();
      end else begin
         acc = bus.cyc_i && bus.stb_i && !m_ack;
         rd  = acc && !bus.we_i;
         wr  = acc && bus.we_i;
         if (acc) exp_q.push_back('{we: bus.we_i, adr: bus.adr_i,
                                    data: rd ? model_read(bus.adr_i) : 32'h0});
         ctrl_new = (wr && bus.adr_i == 4'd0) ? bus.dat_i[7:0] : m_ctrl;
         w1c      = (wr && bus.adr_i == 4'd2) ? bus.dat_i[7:0] : 8'h00;
         ovr_set  = '0;
         for (int n = 0; n < 8; n++) begin
            logic hit_rd, captured;
            hit_rd   = rd && (bus.adr_i == 4'(8 + n));
            captured = 1'b0;
            if (!ctrl_new[n] || !m_ctrl[n]) begin
               m_armed[n] = 1'b0;
            end else if (rise_at[n] == cyc_count) begin
               if (!m_armed[n]) begin
                  m_armed[n] = 1'b1;
               end else begin
                  m_per[n] = sat32(cyc_count - m_last[n]);
                  if (m_valid[n] && !hit_rd) ovr_set[n] = 1'b1;
                  m_valid[n] = 1'b1;
                  captured = 1'b1;
               end
               m_last[n] = cyc_count;
            end
            if (hit_rd && !captured) m_valid[n] = 1'b0;
            if (rise_at[n] == cyc_count) m_hrise[n] = cyc_count;
            if (fall_at[n] == cyc_count && m_hrise[n] >= 0)
               m_high[n] = sat32(cyc_count - m_hrise[n]);
         end
         m_ovr = (m_ovr & ~w1c) | ovr_set;
         if (wr && bus.adr_i == 4'd3) m_chsel = bus.dat_i[2:0];
         m_ctrl = ctrl_new;
         m_ack  = acc;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.ack_o || m_ack) begin
            check("ack_timing", 32'(bus.ack_o), 32'(m_ack));
            if (m_ack && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (bus.ack_o) begin
                  $display("%s adr=%0d dat_o=%08h expect=%08h", e.we ? "wr" : "rd",
                           e.adr, bus.dat_o, e.data);
                  check($sformatf("dat_o adr%0d", e.adr), bus.dat_o, e.data);
               end
            end
         end else begin
            check("dat_o_idle", bus.dat_o, 32'h0);
         end
      end
   end

   task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d);
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = w; bus.adr_i = a; bus.dat_i = d;
      @(posedge clk);
      @(negedge clk);
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input logic [3:0] a);
      xfer(1'b0, a, 32'h0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      xfer(1'b1, a, d);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_wave(input int ch, input int p, input int h);
      per_cfg[ch] = p;
      hi_cfg[ch]  = h;
   endtask

   task automatic wait_pending(input int ch);
      int guard;
      guard = 0;
      while (rise_at[ch] <= cyc_count && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL edge_timeout ch%0d: got no edge, expected one within 2000 cycles", ch);
      end
   endtask

   task automatic wait_edge(input int ch);
      wait_pending(ch);
      while (cyc_count < rise_at[ch]) @(negedge clk);
   endtask

   initial begin
      int op, ch, p;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      bus.adr_i = '0;   bus.dat_i = '0;
      repeat (4) @(negedge clk);
      check("reset_ack", 32'(bus.ack_o), 32'h0);
      check("reset_dat", bus.dat_o, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 16; a++) rd(4'(a));

      // basic period
      wr(4'd0, 32'h01);
      set_wave(0, 300, 150);
      wait_cycles(320);
      rd(4'd1); rd(4'd8); rd(4'd1);

      // period change without reads -> overrun
      set_wave(0, 280, 140);
      wait_cycles(1150);
      rd(4'd2); rd(4'd8);
      wr(4'd2, 32'h01);
      rd(4'd2);

      // channels 0 and 7 in lockstep, then disable mid-period and re-enable
      set_wave(0, 0, 0);
      wait_cycles(320);
      set_wave(0, 272, 136);
      set_wave(7, 272, 136);
      wr(4'd0, 32'hFF);
      wait_cycles(3 * 272 + 20);
      wait_edge(0);
      wait_cycles(50);
      rd(4'd8); rd(4'd15);
      wr(4'd0, 32'h00);
      wait_cycles(50);
      wr(4'd0, 32'hFF);
      wait_edge(0);
      wait_cycles(4);
      rd(4'd1);
      wait_edge(0);
      wait_cycles(4);
      rd(4'd1); rd(4'd15);

      // PERIOD[0] read accepted exactly on the capture edge
      wr(4'd2, 32'hFF);
      wait_pending(0);
      while (cyc_count < rise_at[0] - 1) @(negedge clk);
      rd(4'd8);
      rd(4'd1); rd(4'd2); rd(4'd8);

      // high time (reads 0 when the feature is not built)
      set_wave(0, 100, 30);
      wait_cycles(272 + 350);
      wr(4'd3, 32'h0);
      rd(4'd3); rd(4'd4); rd(4'd8);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               ch = $urandom_range(0, 7);
               p  = $urandom_range(4, 64);
               set_wave(ch, p, $urandom_range(2, p - 2));
            end
            1: wr(4'd0, 32'($urandom_range(0, 255)));
            2: rd(4'($urandom_range(0, 15)));
            3: wr(4'd2, 32'($urandom_range(0, 255)));
            4: wr(4'd3, $urandom);
            default: wr(4'($urandom_range(5, 15)), $urandom);
         endcase
         wait_cycles($urandom_range(0, 40));
      end
      for (int a = 0; a < 16; a++) rd(4'(a));
      wait_cycles(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
